// File: rtl/sqrt_arbiter_if.sv
// Bundle between the requesters, the response consumer and the shared iterate square-root core.
interface sqrt_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*23-1:0] req_op;
    logic [NREQ-1:0]    gnt;
    logic               busy;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_sign;
    logic [6:0]         rsp_exp;
    logic [10:0]        rsp_mant;
    logic               rsp_err;

    logic               it_enable;
    logic               it_n_valid;
    logic               it_sign;
    logic               it_is_nan;
    logic               it_is_pinf;
    logic               it_is_ninf;
    logic               it_is_num;
    logic [6:0]         it_exp;
    logic [10:0]        it_mant;
    logic               it_valid;
    logic               it_result;
    logic               it_sign_out;
    logic [6:0]         it_exp_out;
    logic [10:0]        it_mant_out;

    modport master (
        input  req, req_op, rsp_ready,
        input  it_valid, it_result, it_sign_out, it_exp_out, it_mant_out,
        output gnt, busy,
        output rsp_valid, rsp_id, rsp_sign, rsp_exp, rsp_mant, rsp_err,
        output it_enable, it_n_valid, it_sign, it_is_nan, it_is_pinf, it_is_ninf,
        output it_is_num, it_exp, it_mant
    );

    modport slave (
        output req, req_op, rsp_ready,
        output it_valid, it_result, it_sign_out, it_exp_out, it_mant_out,
        input  gnt, busy,
        input  rsp_valid, rsp_id, rsp_sign, rsp_exp, rsp_mant, rsp_err,
        input  it_enable, it_n_valid, it_sign, it_is_nan, it_is_pinf, it_is_ninf,
        input  it_is_num, it_exp, it_mant
    );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one iterate square-root core between NREQ requesters,
// with a completion watchdog and a valid/ready response port.
module sqrt_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 31
) (
    input  logic          clk,
    input  logic          enable,
    sqrt_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [IDW-1:0] r_rrPtr;
    logic [IDW-1:0] w_pickIdx;
    logic [IDW-1:0] w_scanIdx;
    logic           w_pickFound;
    logic           w_grant;
    logic           w_done;
    logic           w_timeout;
    logic [22:0]    r_op;
    logic [IDW-1:0] r_id;
    logic [CW-1:0]  r_cnt;
    logic           r_rspSign;
    logic [6:0]     r_rspExp;
    logic [10:0]    r_rspMant;
    logic           r_rspErr;

    // First pending requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_pickFound = 1'b0;
        w_pickIdx   = r_rrPtr;
        w_scanIdx   = r_rrPtr;
        for (int k = 0; k < NREQ; k++) begin
            w_scanIdx = r_rrPtr + IDW'(k);
            if (!w_pickFound && bus.req[w_scanIdx]) begin
                w_pickFound = 1'b1;
                w_pickIdx   = w_scanIdx;
            end
        end
    end

    assign w_grant   = enable && (r_state == S_IDLE) && w_pickFound;
    assign w_done    = bus.it_valid && bus.it_result;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_stateNext    = r_state;
        bus.gnt        = '0;
        bus.it_enable  = 1'b0;
        bus.it_n_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    bus.gnt[w_pickIdx] = 1'b1;
                    w_stateNext        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.it_enable  = 1'b1;
                bus.it_n_valid = 1'b1;
                w_stateNext    = S_WAIT;
            end
            S_WAIT: begin
                bus.it_enable = 1'b1;
                if (w_done || w_timeout) begin
                    w_stateNext = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // A real result beats a simultaneous watchdog expiry.
    always_ff @(posedge clk) begin
        if (!enable) begin
            r_state   <= S_IDLE;
            r_rrPtr   <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_id      <= '0;
            r_rspSign <= 1'b0;
            r_rspExp  <= '0;
            r_rspMant <= '0;
            r_rspErr  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_grant) begin
                r_op    <= bus.req_op[int'(w_pickIdx)*23 +: 23];
                r_id    <= w_pickIdx;
                r_rrPtr <= w_pickIdx + 1'b1;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (w_done) begin
                    r_rspSign <= bus.it_sign_out;
                    r_rspExp  <= bus.it_exp_out;
                    r_rspMant <= bus.it_mant_out;
                    r_rspErr  <= 1'b0;
                end else if (w_timeout) begin
                    r_rspSign <= 1'b1;
                    r_rspExp  <= 7'd16;
                    r_rspMant <= 11'h400;
                    r_rspErr  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sign  = r_rspSign;
    assign bus.rsp_exp   = r_rspExp;
    assign bus.rsp_mant  = r_rspMant;
    assign bus.rsp_err   = r_rspErr;

    assign bus.it_sign    = r_op[22];
    assign bus.it_is_nan  = r_op[21];
    assign bus.it_is_pinf = r_op[20];
    assign bus.it_is_ninf = r_op[19];
    assign bus.it_is_num  = r_op[18];
    assign bus.it_exp     = r_op[17:11];
    assign bus.it_mant    = r_op[10:0];
endmodule
